// File: rtl/nios_irq_ctrl_pkg.sv
// Shared constants for the Nios interrupt aggregator: register map, limits and
// a helper that builds the mask of implemented irq bits.
package nios_irq_ctrl_pkg;

  localparam int IRQC_MAX_IRQ = 16;

  localparam logic [2:0] IRQC_PENDING = 3'd0;
  localparam logic [2:0] IRQC_MASK    = 3'd1;
  localparam logic [2:0] IRQC_EDGE    = 3'd2;
  localparam logic [2:0] IRQC_STATUS  = 3'd3;
  localparam logic [2:0] IRQC_ACTIVE  = 3'd4;
  localparam logic [2:0] IRQC_RAW     = 3'd5;

  localparam int IRQC_ACTIVE_VALID_BIT = 15;

  // Ones in the low n bits of a 16-bit register, zeros above.
  function automatic logic [15:0] irqc_impl_mask(input int n);
    return (n >= IRQC_MAX_IRQ) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/nios_irq_prio_enc.sv
// Combinational 16-bit priority encoder: reports the lowest-index set bit.
module nios_irq_prio_enc (
  input  logic [15:0] i_vec,
  output logic [3:0]  o_id,
  output logic        o_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (i_vec[i]) o_id = 4'(i);
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/nios_irq_ctrl.sv
// Avalon-MM interrupt aggregator. Each irq line is synchronised, captured as
// level or rising edge, masked, and the lowest-index enabled source is
// reported in ACTIVE. Internal registers are 16 bits wide; bits at or above
// NUM_IRQ are held at zero by the implemented-bit mask.
module nios_irq_ctrl
  import nios_irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] EDGE_RESET  = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [15:0] L_IMPL = irqc_impl_mask(NUM_IRQ);
  localparam logic [1:0]  L_WARM = 2'(SYNC_STAGES);

  logic [NUM_IRQ-1:0] w_raw_s;
  logic [15:0]        w_raw16;
  logic [15:0]        r_pend;
  logic [15:0]        r_mask;
  logic [15:0]        r_edge;
  logic [15:0]        r_prev;
  logic [1:0]         r_warm;
  logic               r_irq;
  logic [15:0]        r_rdata;
  logic               w_warm_done;
  logic               w_wr;
  logic               w_wr_pend;
  logic               w_wr_mask;
  logic               w_wr_edge;
  logic [15:0]        w_mode_chg;
  logic [15:0]        w_clr;
  logic [15:0]        w_rise;
  logic [15:0]        w_pend_next;
  logic [15:0]        w_status;
  logic [15:0]        w_active;
  logic [3:0]         w_id;
  logic               w_valid;
  logic [15:0]        w_rd_mux;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign w_raw_s = irq_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
      // Shift each irq line through SYNC_STAGES flops.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= irq_in;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_raw_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Widen the synchronised levels to register width.
  always_comb begin
    w_raw16 = '0;
    w_raw16[NUM_IRQ-1:0] = w_raw_s;
  end

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_pend = w_wr & (address == IRQC_PENDING);
  assign w_wr_mask = w_wr & (address == IRQC_MASK);
  assign w_wr_edge = w_wr & (address == IRQC_EDGE);

  // A mode change wipes the bit in the write cycle; a W1C hits edge bits only
  // and loses to a simultaneous rising edge.
  assign w_warm_done = (r_warm == L_WARM);
  assign w_mode_chg  = w_wr_edge ? ((writedata ^ r_edge) & L_IMPL) : 16'h0000;
  assign w_clr       = w_wr_pend ? writedata : 16'h0000;
  assign w_rise      = w_raw16 & ~r_prev;
  assign w_pend_next = ((r_edge & (w_rise | (r_pend & ~w_clr))) |
                        (~r_edge & w_raw16)) & ~w_mode_chg & L_IMPL;

  // Count synchroniser flush cycles after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             r_warm <= 2'd0;
    else if (!w_warm_done) r_warm <= r_warm + 2'd1;
  end

  // prev holds its all-ones reset value until the synchroniser has flushed,
  // so a line already high at reset release never looks like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_prev <= 16'hFFFF;
    else if (w_warm_done) r_prev <= w_raw16;
  end

  // Pending capture plus the MASK and EDGE control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= 16'h0000;
      r_mask <= 16'h0000;
      r_edge <= EDGE_RESET & L_IMPL;
    end else begin
      r_pend <= w_pend_next;
      if (w_wr_mask) r_mask <= writedata & L_IMPL;
      if (w_wr_edge) r_edge <= writedata & L_IMPL;
    end
  end

  assign w_status = r_pend & r_mask;

  nios_irq_prio_enc u_prio (
    .i_vec   (w_status),
    .o_id    (w_id),
    .o_valid (w_valid)
  );

  // ACTIVE word: valid flag in bit 15, source id in the low nibble.
  always_comb begin
    w_active = 16'h0000;
    if (w_valid) begin
      w_active[IRQC_ACTIVE_VALID_BIT] = 1'b1;
      w_active[3:0]                   = w_id;
    end
  end

  // Read mux, decoded from address alone.
  always_comb begin
    w_rd_mux = 16'h0000;
    case (address)
      IRQC_PENDING: w_rd_mux = r_pend;
      IRQC_MASK:    w_rd_mux = r_mask;
      IRQC_EDGE:    w_rd_mux = r_edge;
      IRQC_STATUS:  w_rd_mux = w_status;
      IRQC_ACTIVE:  w_rd_mux = w_active;
      IRQC_RAW:     w_rd_mux = w_raw16;
      default:      w_rd_mux = 16'h0000;
    endcase
  end

  // Registered irq and read data, updated every clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq   <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_irq   <= |w_status;
      r_rdata <= w_rd_mux;
    end
  end

  assign irq      = r_irq;
  assign readdata = r_rdata;

endmodule
